// File: rtl/uart_rx_packetizer_pkg.sv
// Shared types for the UART receive packetizer.
// A FIFO entry is one received byte plus its end-of-packet flag.
package uart_rx_packetizer_pkg;

   typedef enum logic {
      ST_IDLE,
      ST_HOLD
   } state_t;

   typedef struct packed {
      logic       last;
      logic [7:0] data;
   } beat_t;

endpackage

// File: rtl/uart_rx_packetizer_fifo.sv
// Synchronous packet FIFO with a registered read port.
// count tracks entries still held in the RAM (not yet read out).
module uart_rx_packetizer_fifo
   import uart_rx_packetizer_pkg::*;
#(
   parameter int EA = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  beat_t       wr_data,
   input  logic        rd_en,
   output beat_t       rd_data,
   output logic [EA:0] count
);

   localparam int DEPTH = 2 ** EA;

   beat_t         mem [DEPTH];
   logic [EA-1:0] wr_ptr;
   logic [EA-1:0] rd_ptr;

   // RAM array carries no reset so it maps onto block RAM
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         rd_data <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) begin
            rd_ptr  <= rd_ptr + 1'b1;
            rd_data <= mem[rd_ptr];
         end
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_packetizer.sv
// Frames a UART byte stream into packets by idle-gap timeout and
// presents them as an AXI-stream with tlast on each packet's last byte.
module uart_rx_packetizer
   import uart_rx_packetizer_pkg::*;
#(
   parameter int IDLE_TIMEOUT = 1000000,
   parameter int FIFO_EA      = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_en,
   input  logic [7:0] i_data,
   input  logic       o_tready,
   output logic       o_tvalid,
   output logic [7:0] o_tdata,
   output logic       o_tlast,
   output logic       o_overflow,
   output logic       during_packet
);

   localparam int DEPTH = 2 ** FIFO_EA;
   localparam int CW    = $clog2(IDLE_TIMEOUT);
   localparam int OW    = FIFO_EA + 1;

   localparam logic [CW-1:0] CNT_MAX   = CW'(IDLE_TIMEOUT - 1);
   localparam logic [OW-1:0] OCC_FULL  = OW'(DEPTH);
   localparam logic [OW-1:0] OCC_SOFT  = OW'(DEPTH - 1);

   state_t        state;
   logic [7:0]    hold_reg;
   logic [CW-1:0] cnt;

   logic [OW-1:0] fifo_count;
   logic [OW-1:0] occ;
   beat_t         rd_beat;
   beat_t         push_beat;
   logic          want_push;
   logic          push_last;
   logic          room;
   logic          wr_en;
   logic          drop;
   logic          rd_en;

   // The output stage counts as occupied storage, leaving one slot
   // in reserve so a closing tlast entry is never refused.
   always_comb begin
      occ       = fifo_count + {{(OW-1){1'b0}}, o_tvalid};
      want_push = (state == ST_HOLD) && (i_en || cnt == CNT_MAX);
      push_last = want_push && !i_en;
      room      = push_last ? (occ < OCC_FULL) : (occ < OCC_SOFT);
      wr_en     = want_push && room;
      drop      = want_push && !room;
      push_beat = '{last: push_last, data: hold_reg};
      rd_en     = (fifo_count != '0) && (!o_tvalid || o_tready);
   end

   uart_rx_packetizer_fifo #(
      .EA (FIFO_EA)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_data (push_beat),
      .rd_en   (rd_en),
      .rd_data (rd_beat),
      .count   (fifo_count)
   );

   assign o_tdata = rd_beat.data;
   assign o_tlast = rd_beat.last;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         hold_reg      <= '0;
         cnt           <= '0;
         during_packet <= 1'b0;
         o_overflow    <= 1'b0;
         o_tvalid      <= 1'b0;
      end else begin
         o_overflow <= drop;
         o_tvalid   <= rd_en || (o_tvalid && !o_tready);
         case (state)
            ST_IDLE: begin
               if (i_en) begin
                  hold_reg      <= i_data;
                  cnt           <= '0;
                  state         <= ST_HOLD;
                  during_packet <= 1'b1;
               end
            end
            ST_HOLD: begin
               if (i_en) begin
                  hold_reg <= i_data;
                  cnt      <= '0;
               end else if (cnt == CNT_MAX) begin
                  state         <= ST_IDLE;
                  during_packet <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
